pipe_redirect_ctrl: RTL
=======================

// Module: pipe_redirect_ctrl
// PURPOSE
//  Sits between the execute stage, the interrupt and exception sources and the pc unit, and is the only driver of
//  jump_cause/jump_from/jump_to/hold_flag into pc. Arbitrates redirect requests and registers one winner per cycle.
//  After each redirect it flushes younger stages for a fixed bubble window. Also merges stall requests into one
//  hold bus and counts branch mispredicts.
// PARAMETERS
//  ADDR_W        32  instruction address width
//  FLUSH_CYCLES  2   bubble cycles after a redirect (1..7)
// PORTS
//  clk               in   1       clock
//  rst_n             in   1       synchronous, active-high reset (asserted when 1)
//  ex_jump_req_i     in   1       execute resolves a redirect this cycle
//  ex_jump_cause_i   in   3       1 nocondition, 2 predict_no_but_yes, 3 predict_yes_but_no
//  ex_from_addr_i    in   ADDR_W  pc of the redirecting instruction
//  ex_to_addr_i      in   ADDR_W  redirect target
//  exc_req_i         in   1       exception raised by the instruction in EX
//  exc_pc_i          in   ADDR_W  pc of the faulting instruction
//  trap_vec_i        in   ADDR_W  trap handler base (shared by exceptions and irqs)
//  irq_req_i         in   1       level interrupt request
//  irq_resume_pc_i   in   ADDR_W  pc of the oldest unretired instruction (resume point)
//  irq_ack_o         out  1       one-cycle pulse: interrupt taken
//  stall_if_i        in   1       fetch bus stall
//  stall_mem_i       in   1       data bus stall
//  jtag_halt_i       in   1       debugger halt request (level)
//  jump_cause_o      out  3       0 none, 1..3 as above, 4 interrupt, 5 exception
//  jump_from_addr_o  out  ADDR_W  redirect source pc
//  jump_to_addr_o    out  ADDR_W  redirect target
//  hold_flag_o       out  3       bit0 pc, bit1 if/id, bit2 id/ex; 0 = no hold
//  flush_o           out  1       kill if/id and id/ex contents
//  epc_o             out  ADDR_W  saved return pc for the last trap
//  mispred_cnt_o     out  16      saturating mispredict count
// BEHAVIOUR
//  Reset: state IDLE; jump_cause_o=0, jump_*_addr_o=0, flush_o=0, irq_ack_o=0, epc_o=0, mispred_cnt_o=0, irq
//  pending=0. hold_flag_o then follows its inputs combinationally.
//  FSM states: IDLE, REDIR, FLUSH, HALT.
//  IDLE arbitration (fixed priority): exc_req_i > ex_jump_req_i > pending irq. A winner in cycle N -> registered
//  jump_* outputs valid for exactly cycle N+1 (state REDIR); all other jump_cause_o cycles are 0.
//   - exception: cause 5; from=exc_pc_i; to=trap_vec_i; epc_o<=exc_pc_i.
//   - ex jump: cause, from and to copied from the ex_* inputs.
//   - irq: cause 4; from=irq_resume_pc_i; to=trap_vec_i; epc_o<=irq_resume_pc_i; irq_ack_o pulses in N+1.
//  irq pending: set on irq_req_i in any state; cleared by ack. It is taken only in IDLE with stall_mem_i=0 and no
//  exc/ex request. Losers at the same cycle: an ex jump that loses to an exception is dropped; irq stays pending.
//  REDIR -> FLUSH: flush_o=1 in REDIR and for FLUSH_CYCLES-1 further FLUSH cycles (total FLUSH_CYCLES). FLUSH counter
//  counts down to 1 and then returns to IDLE. In REDIR and FLUSH, ex_jump_req_i and exc_req_i are ignored (wrong
//  path).
//  HALT: entered from IDLE when jtag_halt_i=1 and no request wins; hold_flag_o=3'b111; irqs latch but are not
//  taken. On jtag_halt_i=0 -> IDLE the next cycle. A halt raised during REDIR or FLUSH is deferred until IDLE.
//  hold_flag_o (combinational; forced to 0 in REDIR so the pc accepts the jump):
//   HALT or stall_mem_i -> 3'b111; else stall_if_i -> 3'b011; else 3'b000.
//  A stall during FLUSH freezes the FLUSH counter; flush_o stays 1.
//  mispred_cnt_o +1 on each REDIR with cause 2 or 3; saturates at 16'hFFFF without wrapping.
//  Reset mid-operation: returns to IDLE in the next cycle; pending irq and any in-flight redirect are discarded.
// CONFIGURATION
//  PIPE_REDIRECT_IRQ_EN defined: interrupt path as above.
//  PIPE_REDIRECT_IRQ_EN undefined: no pending flop; irq_req_i and irq_resume_pc_i are ignored; irq_ack_o is tied to
//  0; cause 4 is never produced. The epc_o exception path is unchanged.
// TESTING
//  1 ex_jump_req_i=1, cause 3, from 0x100, to 0x104 at cycle N -> cycle N+1 cause=3, to=0x104;
//    flush_o=1 in N+1..N+2; mispred_cnt_o=1.
//  2 exc_req_i and ex_jump_req_i both 1, exc_pc_i=0x200, trap_vec_i=0x80 -> cause=5, to=0x80, epc_o=0x200;
//    the ex jump is never issued.
//  3 irq_req_i pulses for 1 cycle during FLUSH -> irq is taken in the first IDLE cycle; cause=4; irq_ack_o pulses once.
//  4 stall_mem_i=1 with irq pending in IDLE -> hold_flag_o=3'b111 and no ack; stall drops -> irq taken the next cycle.
//  5 jtag_halt_i=1 for 5 cycles in IDLE -> hold_flag_o=3'b111 for those cycles; IDLE and hold_flag_o=0 one cycle
//    after release.
//  6 Preload 16'hFFFF, then mispredict -> counter stays 16'hFFFF. Compile without the macro and raise irq_req_i ->
//    jump_cause_o stays 0.

Source files
------------

// File: rtl/pipe_redirect_ctrl_if.sv
// pipe_redirect_ctrl_if: execute/trap/stall requests in, pc-side redirect and hold outputs back
interface pipe_redirect_ctrl_if #(parameter int ADDR_W = 32);
  logic              ex_jump_req_i;
  logic [2:0]        ex_jump_cause_i;
  logic [ADDR_W-1:0] ex_from_addr_i;
  logic [ADDR_W-1:0] ex_to_addr_i;
  logic              exc_req_i;
  logic [ADDR_W-1:0] exc_pc_i;
  logic [ADDR_W-1:0] trap_vec_i;
  logic              irq_req_i;
  logic [ADDR_W-1:0] irq_resume_pc_i;
  logic              irq_ack_o;
  logic              stall_if_i;
  logic              stall_mem_i;
  logic              jtag_halt_i;
  logic [2:0]        jump_cause_o;
  logic [ADDR_W-1:0] jump_from_addr_o;
  logic [ADDR_W-1:0] jump_to_addr_o;
  logic [2:0]        hold_flag_o;
  logic              flush_o;
  logic [ADDR_W-1:0] epc_o;
  logic [15:0]       mispred_cnt_o;
  modport master (
    output ex_jump_req_i, ex_jump_cause_i, ex_from_addr_i, ex_to_addr_i, exc_req_i, exc_pc_i, trap_vec_i,
           irq_req_i, irq_resume_pc_i, stall_if_i, stall_mem_i, jtag_halt_i,
    input  irq_ack_o, jump_cause_o, jump_from_addr_o, jump_to_addr_o, hold_flag_o, flush_o, epc_o, mispred_cnt_o
  );
  modport slave (
    input  ex_jump_req_i, ex_jump_cause_i, ex_from_addr_i, ex_to_addr_i, exc_req_i, exc_pc_i, trap_vec_i,
           irq_req_i, irq_resume_pc_i, stall_if_i, stall_mem_i, jtag_halt_i,
    output irq_ack_o, jump_cause_o, jump_from_addr_o, jump_to_addr_o, hold_flag_o, flush_o, epc_o, mispred_cnt_o
  );
endinterface

// File: rtl/pipe_redirect_ctrl.sv
// pipe_redirect_ctrl: redirect arbiter, flush sequencer, hold merge and mispredict counter; irq path under PIPE_REDIRECT_IRQ_EN
module pipe_redirect_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input logic                clk,
  input logic                rst_n,
  pipe_redirect_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REDIR, FLUSH, HALT} state_t;
  state_t            state, state_nx;
  logic [2:0]        fcnt, fcnt_nx;
  logic [2:0]        cause_q, cause_nx;
  logic [ADDR_W-1:0] from_q, from_nx, to_q, to_nx, epc_q, irq_pc;
  logic              ack_q;
  logic [15:0]       mispred_cnt;
  logic              take_exc, take_jmp, take_irq, win, halt_hold;
  assign take_exc = (state == IDLE) & bus.exc_req_i;
  assign take_jmp = (state == IDLE) & bus.ex_jump_req_i & ~bus.exc_req_i;
`ifdef PIPE_REDIRECT_IRQ_EN
  logic pend;
  assign take_irq = (state == IDLE) & pend & ~bus.stall_mem_i & ~bus.exc_req_i & ~bus.ex_jump_req_i;
  assign irq_pc   = bus.irq_resume_pc_i;
  always_ff @(posedge clk)
    if (rst_n) pend <= 1'b0;
    else       pend <= (pend & ~take_irq) | bus.irq_req_i;
`else
  logic unused_irq;
  assign unused_irq = ^{bus.irq_req_i, bus.irq_resume_pc_i};
  assign take_irq   = 1'b0;
  assign irq_pc     = '0;
`endif
  assign win       = take_exc | take_jmp | take_irq;
  assign halt_hold = (state == HALT) | ((state == IDLE) & bus.jtag_halt_i & ~win);
  always_comb begin
    state_nx = state;
    fcnt_nx  = fcnt;
    cause_nx = take_exc ? 3'd5 : take_jmp ? bus.ex_jump_cause_i : take_irq ? 3'd4 : 3'd0;
    from_nx  = take_exc ? bus.exc_pc_i : take_jmp ? bus.ex_from_addr_i : take_irq ? irq_pc : '0;
    to_nx    = (take_exc | take_irq) ? bus.trap_vec_i : take_jmp ? bus.ex_to_addr_i : '0;
    case (state)
      IDLE:  state_nx = win ? REDIR : bus.jtag_halt_i ? HALT : IDLE;
      REDIR: begin
        state_nx = (FLUSH_CYCLES > 1) ? FLUSH : IDLE;
        fcnt_nx  = 3'(FLUSH_CYCLES - 1);
      end
      FLUSH: if (!(bus.stall_mem_i | bus.stall_if_i)) begin
        state_nx = (fcnt == 3'd1) ? IDLE : FLUSH;
        fcnt_nx  = fcnt - 3'd1;
      end
      HALT:  state_nx = bus.jtag_halt_i ? HALT : IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst_n) begin
      state       <= IDLE;
      fcnt        <= '0;
      cause_q     <= '0;
      from_q      <= '0;
      to_q        <= '0;
      ack_q       <= 1'b0;
      epc_q       <= '0;
      mispred_cnt <= '0;
    end else begin
      state   <= state_nx;
      fcnt    <= fcnt_nx;
      cause_q <= cause_nx;
      from_q  <= from_nx;
      to_q    <= to_nx;
      ack_q   <= take_irq;
      if (take_exc) epc_q <= bus.exc_pc_i;
      else if (take_irq) epc_q <= irq_pc;
      if (state == REDIR && (cause_q == 3'd2 || cause_q == 3'd3) && mispred_cnt != 16'hFFFF)
        mispred_cnt <= mispred_cnt + 16'd1;
    end
  // the pc must be free to load the jump in REDIR, so no hold there
  assign bus.hold_flag_o      = (state == REDIR) ? 3'b000 : (halt_hold | bus.stall_mem_i) ? 3'b111 :
                                bus.stall_if_i ? 3'b011 : 3'b000;
  assign bus.flush_o          = (state == REDIR) | (state == FLUSH);
  assign bus.jump_cause_o     = cause_q;
  assign bus.jump_from_addr_o = from_q;
  assign bus.jump_to_addr_o   = to_q;
  assign bus.irq_ack_o        = ack_q;
  assign bus.epc_o            = epc_q;
  assign bus.mispred_cnt_o    = mispred_cnt;
endmodule
